mux_channel_scanner: RTL and testbench
======================================

# mux_channel_scanner

Sequencer that sits directly upstream of the 8:1 behavioural mux. It drives the mux select lines through the enabled channels in a round-robin scan and samples the mux output after a settle delay. Each sample goes to the downstream consumer over a valid/ready handshake, tagged with its channel number. The scan supports single-frame or continuous operation, with a per-channel dwell time.

## Interface
- SEL_W, 3: select width; channel count N = 2**SEL_W
- SETTLE, 2: cycles the select is held before sampling (≥1)
- DWELL_W, 8: width of the dwell input
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; honoured only in IDLE
- stop  in  1  level; ends the scan at the next channel boundary
- continuous  in  1  1 = restart the frame after the last channel; latched at start
- ch_mask  in  N  channel enables; latched at start
- dwell  in  DWELL_W  extra idle cycles after each accepted sample; latched at start
- mux_out  in  1  output of the 8:1 mux instance
- sel  out  SEL_W  drives the mux Select_Line
- sample_valid  out  1  sample_bit/sample_ch are valid
- sample_ready  in  1  consumer accepts when valid&&ready
- sample_bit  out  1  captured mux_out
- sample_ch  out  SEL_W  channel of sample_bit
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse at the end of each frame

## Operation
- States: IDLE, SETTLE, SAMPLE, DWELL.
- IDLE → SETTLE on start with latched mask ≠ 0:
  - sel = lowest enabled channel
  - settle counter = SETTLE−1
- start with mask == 0: frame_done pulses the next cycle; the block stays IDLE.
- start while busy: ignored.
- SETTLE: sel is held and the counter decrements. At 0, mux_out is captured into sample_bit and sample_ch = sel. Next state is SAMPLE with sample_valid = 1.
- SAMPLE: sample_valid, sample_bit and sample_ch stay stable until sample_ready. On handshake:
  - sample_valid drops
  - if dwell_l ≠ 0 → DWELL (counter = dwell_l−1)
  - otherwise the advance happens immediately
- DWELL: counts down, then advances.
- Advance:
  - Next channel = next enabled channel above sel, wrapping modulo N.
  - If this wrap passes the last enabled channel (end of frame): frame_done pulses, and the block re-enters SETTLE on the lowest enabled channel if continuous_l && !stop, else goes to IDLE.
  - Otherwise → SETTLE on the next channel.
  - stop sampled at advance → IDLE. No frame_done unless the frame completed.
- Single enabled channel: every advance is an end of frame.
- sel changes only on entry to SETTLE and holds otherwise. In IDLE it keeps its last value.

## Timing
- Reset values:
  - state IDLE
  - sel 0
  - sample_valid 0
  - sample_bit 0
  - sample_ch 0
  - busy 0
  - frame_done 0
  - latched mask, dwell and continuous = 0
- rst_n low mid-scan: immediate return to the reset values; a pending sample is discarded.
- Latency with start in cycle 0:
  - sel and busy are valid in cycle 1
  - mux_out is captured at the end of cycle SETTLE
  - sample_valid is high from cycle SETTLE+1
- Handshake in cycle k with dwell 0: the next SETTLE starts at cycle k+1 with the new sel.
- With dwell D: the next SETTLE starts at cycle k+1+D.
- frame_done is asserted in the cycle after the final advance, together with busy if continuing.
- mux_out is combinational from sel; the block registers it only on the SETTLE→SAMPLE edge.
- Backpressure holds the scan indefinitely without loss.

## Structure
- Shared include mux_scan_defs.vh:
  - state encodings (2-bit localparams)
  - the default SEL_W / SETTLE values
- The priority next-enabled-channel finder is one combinational sub-module, `next_channel_pick`:
  - inputs: mask, current sel, wrap flag
  - outputs: next channel, frame-end flag
- The top level instantiates Eight_to_One_Mux only in the bench, not in this block.

## Test plan
- mask=8'hFF, dwell=0, SETTLE=2, ready tied 1, data=8'b1010_0101, single frame → 8 samples in order ch0..7 with bits 1,0,1,0,0,1,0,1; frame_done once; busy falls after it.
- mask=8'h24, continuous=1 → channels 2,5,2,5…; frame_done after every ch5 sample; stop asserted → IDLE at the next boundary, with no further sample_valid.
- ready held low 10 cycles during the ch3 sample → sample_valid, bit and ch stable for 10 cycles, sel stays 3, no sample lost.
- dwell=5, mask=8'h03 → handshake in cycle k; ch1 SETTLE begins at k+6; sel changes at k+6.
- mask=0 start → frame_done pulses one cycle after start, busy stays 0; start during busy → ignored (ch order unchanged).
- rst_n low during SAMPLE → all outputs return to 0 asynchronously; after release, a fresh start begins at the lowest enabled channel.

Source files
------------

// File: rtl/mux_channel_scanner_pkg.sv
// Shared definitions for the mux channel scanner: scan state encodings,
// default geometry and the shared counter-width helper.
package mux_channel_scanner_pkg;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_SETTLE  = 2;
    localparam int DEF_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DWELL  = 2'd3
    } scan_state_t;

    // One down-counter serves both the settle and the dwell phases, so it must
    // be wide enough to hold SETTLE-1 as well as any dwell value.
    function automatic int cnt_width(input int settle, input int dwell_w);
        int sw;
        sw = (settle > 1) ? $clog2(settle) : 1;
        return (dwell_w > sw) ? dwell_w : sw;
    endfunction

endpackage

// File: rtl/mux_channel_scanner_next_channel_pick.sv
// Combinational priority finder: next enabled channel above the current select,
// wrapping to the lowest enabled channel and flagging the end of a frame.
module next_channel_pick
    import mux_channel_scanner_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [(1<<SEL_W)-1:0] mask,
    input  logic [SEL_W-1:0]      cur_sel,
    input  logic                  wrap,
    output logic [SEL_W-1:0]      next_ch,
    output logic                  frame_end
);

    localparam int N = 1 << SEL_W;

    logic [SEL_W-1:0] lowest;
    logic [SEL_W-1:0] above;
    logic             above_found;

    always_comb begin
        lowest      = '0;
        above       = '0;
        above_found = 1'b0;
        // Descending scans so the last hit wins, leaving the lowest match.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur_sel))) begin
                above       = SEL_W'(i);
                above_found = 1'b1;
            end
        end
    end

    always_comb begin
        next_ch   = lowest;
        frame_end = 1'b0;
        if (!wrap) begin
            if (above_found) begin
                next_ch = above;
            end else begin
                frame_end = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Round-robin select sequencer for an 8:1 mux: settles each enabled channel,
// samples mux_out and hands the tagged sample downstream over valid/ready.
module mux_channel_scanner
    import mux_channel_scanner_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [(1<<SEL_W)-1:0] ch_mask,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  mux_out,
    output logic [SEL_W-1:0]      sel,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  sample_bit,
    output logic [SEL_W-1:0]      sample_ch,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = cnt_width(SETTLE, DWELL_W);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);

    scan_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       mask_l;
    logic [DWELL_W-1:0] dwell_l;
    logic               cont_l;

    logic [N-1:0]       pick_mask;
    logic               pick_wrap;
    logic [SEL_W-1:0]   next_ch;
    logic               frame_end;
    logic               do_advance;
    logic               go_idle;

    // In IDLE the finder looks at the live mask so the first select is ready
    // on the cycle after start, before the latched copy exists.
    assign pick_mask = (state == ST_IDLE) ? ch_mask : mask_l;
    assign pick_wrap = (state == ST_IDLE);

    next_channel_pick #(
        .SEL_W (SEL_W)
    ) u_pick (
        .mask      (pick_mask),
        .cur_sel   (sel),
        .wrap      (pick_wrap),
        .next_ch   (next_ch),
        .frame_end (frame_end)
    );

    always_comb begin
        do_advance = 1'b0;
        if (state == ST_SAMPLE && sample_ready && dwell_l == '0) begin
            do_advance = 1'b1;
        end else if (state == ST_DWELL && cnt == '0) begin
            do_advance = 1'b1;
        end
    end

    assign go_idle = stop || (frame_end && !cont_l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mask_l       <= '0;
            dwell_l      <= '0;
            cont_l       <= 1'b0;
            sel          <= '0;
            sample_valid <= 1'b0;
            sample_bit   <= 1'b0;
            sample_ch    <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask_l  <= ch_mask;
                        dwell_l <= dwell;
                        cont_l  <= continuous;
                        if (ch_mask != '0) begin
                            state <= ST_SETTLE;
                            busy  <= 1'b1;
                            sel   <= next_ch;
                            cnt   <= SETTLE_INIT;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        sample_bit   <= mux_out;
                        sample_ch    <= sel;
                        sample_valid <= 1'b1;
                        state        <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (dwell_l != '0) begin
                            state <= ST_DWELL;
                            cnt   <= CNT_W'(dwell_l) - 1'b1;
                        end
                    end
                end
                ST_DWELL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Channel boundary: a stop request wins over a continuous restart,
            // but a completed frame is still reported.
            if (do_advance) begin
                frame_done <= frame_end;
                if (go_idle) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_SETTLE;
                    sel   <= next_ch;
                    cnt   <= SETTLE_INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: behavioural 8:1 mux on sel, scoreboard of
// expected {channel, bit} samples, table-driven frames and corner sequences.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic [7:0] dwell = 8'h00;
    logic       mux_out;
    logic [2:0] sel;
    logic       sample_valid;
    logic       sample_ready = 1'b1;
    logic       sample_bit;
    logic [2:0] sample_ch;
    logic       busy;
    logic       frame_done;

    logic [7:0] mux_data = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int n_pop   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    assign mux_out = mux_data[sel];

    mux_channel_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .ch_mask      (ch_mask),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .sel          (sel),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_bit   (sample_bit),
        .sample_ch    (sample_ch),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", {28'h0, sample_ch, sample_bit}, 32'hFFFF_FFFF);
            end else begin
                check("sample_ch_bit", {28'h0, sample_ch, sample_bit}, {28'h0, exp_q[0]});
                void'(exp_q.pop_front());
            end
            n_pop++;
        end
        if (rst_n && frame_done) fd_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] m, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) exp_q.push_back({3'(i), d[i]});
        end
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] dw, input logic c);
        ch_mask    = m;
        dwell      = dw;
        continuous = c;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int guard;
        guard = 0;
        while (busy && guard < bound) begin
            step();
            guard++;
        end
        if (guard >= bound) check({name, "_timeout"}, 32'd1, 32'd0);
        step();
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dw;
        logic [7:0] data;
        int         n_exp;
        logic [2:0] first;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fd0;
        int pop0;
        int guard;
        logic [3:0] held;

        vecs[0] = '{mask: 8'hFF, dw: 8'd0, data: 8'b1010_0101, n_exp: 8, first: 3'd0};
        vecs[1] = '{mask: 8'h81, dw: 8'd2, data: 8'h3C,        n_exp: 2, first: 3'd0};
        vecs[2] = '{mask: 8'h10, dw: 8'd0, data: 8'hFF,        n_exp: 1, first: 3'd4};
        vecs[3] = '{mask: 8'h6A, dw: 8'd1, data: 8'h5A,        n_exp: 4, first: 3'd1};

        step();
        step();
        check("rst_sel", {29'h0, sel}, 32'd0);
        check("rst_valid", {31'h0, sample_valid}, 32'd0);
        check("rst_bit", {31'h0, sample_bit}, 32'd0);
        check("rst_ch", {29'h0, sample_ch}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_frame_done", {31'h0, frame_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single frames, ready tied high.
        for (int v = 0; v < 4; v++) begin
            mux_data = vecs[v].data;
            fd0  = fd_cnt;
            pop0 = n_pop;
            push_frame(vecs[v].mask, vecs[v].data);
            do_start(vecs[v].mask, vecs[v].dw, 1'b0);
            check("vec_busy_c1", {31'h0, busy}, 32'd1);
            check("vec_sel_c1", {29'h0, sel}, {29'h0, vecs[v].first});
            check("vec_valid_c1", {31'h0, sample_valid}, 32'd0);
            step();
            check("vec_valid_c2", {31'h0, sample_valid}, 32'd0);
            step();
            check("vec_valid_c3", {31'h0, sample_valid}, 32'd1);
            wait_idle("vec", 500);
            check("vec_samples", n_pop - pop0, vecs[v].n_exp);
            check("vec_frame_done", fd_cnt - fd0, 32'd1);
            check("vec_queue_empty", exp_q.size(), 32'd0);
            check("vec_busy_end", {31'h0, busy}, 32'd0);
        end

        // Continuous scan over channels 2 and 5, then stop.
        mux_data = 8'h24;
        fd0 = fd_cnt;
        for (int f = 0; f < 3; f++) push_frame(8'h24, 8'h24);
        exp_q.push_back({3'd2, 1'b1});
        do_start(8'h24, 8'd0, 1'b1);
        guard = 0;
        while (fd_cnt - fd0 < 3 && guard < 300) begin
            step();
            guard++;
        end
        check("cont_frames_seen", fd_cnt - fd0, 32'd3);
        check("cont_busy_after_fd", {31'h0, busy}, 32'd1);
        stop = 1'b1;
        wait_idle("cont_stop", 100);
        stop = 1'b0;
        check("cont_queue_empty", exp_q.size(), 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("cont_no_extra_fd", fd_cnt - fd0, 32'd3);
        check("cont_idle", {31'h0, busy}, 32'd0);

        // Backpressure on channel 3.
        mux_data = 8'h3C;
        fd0 = fd_cnt;
        push_frame(8'hFF, 8'h3C);
        do_start(8'hFF, 8'd0, 1'b0);
        guard = 0;
        while (!(busy && sel == 3'd3 && !sample_valid) && guard < 100) begin
            step();
            guard++;
        end
        sample_ready = 1'b0;
        guard = 0;
        while (!sample_valid && guard < 20) begin
            step();
            guard++;
        end
        held = {sample_ch, sample_bit};
        check("bp_held_value", {28'h0, held}, {28'h0, 3'd3, 1'b1});
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {31'h0, sample_valid}, 32'd1);
            check("bp_ch_bit", {28'h0, sample_ch, sample_bit}, {28'h0, held});
            check("bp_sel", {29'h0, sel}, 32'd3);
            step();
        end
        sample_ready = 1'b1;
        wait_idle("bp", 200);
        check("bp_queue_empty", exp_q.size(), 32'd0);
        check("bp_frame_done", fd_cnt - fd0, 32'd1);

        // Dwell of 5 between channel 0 and channel 1.
        mux_data = 8'h01;
        push_frame(8'h03, 8'h01);
        do_start(8'h03, 8'd5, 1'b0);
        guard = 0;
        while (!(sample_valid && sample_ch == 3'd0) && guard < 20) begin
            step();
            guard++;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            check("dwell_sel", {29'h0, sel}, (c == 6) ? 32'd1 : 32'd0);
            check("dwell_valid", {31'h0, sample_valid}, 32'd0);
        end
        wait_idle("dwell", 100);
        check("dwell_queue_empty", exp_q.size(), 32'd0);

        // Empty mask: immediate frame_done, no scan.
        do_start(8'h00, 8'd0, 1'b0);
        check("empty_fd", {31'h0, frame_done}, 32'd1);
        check("empty_busy", {31'h0, busy}, 32'd0);
        step();
        check("empty_fd_pulse", {31'h0, frame_done}, 32'd0);

        // Start while busy is ignored.
        mux_data = 8'h10;
        fd0 = fd_cnt;
        push_frame(8'h11, 8'h10);
        do_start(8'h11, 8'd0, 1'b0);
        ch_mask = 8'h02;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_idle("busy_start", 100);
        check("busy_start_queue", exp_q.size(), 32'd0);
        check("busy_start_fd", fd_cnt - fd0, 32'd1);

        // Asynchronous reset while a sample is pending.
        mux_data = 8'hFF;
        sample_ready = 1'b0;
        exp_q.push_back({3'd2, 1'b1});
        do_start(8'h0C, 8'd0, 1'b0);
        guard = 0;
        while (!sample_valid && guard < 20) begin
            step();
            guard++;
        end
        check("arst_pre_valid", {31'h0, sample_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", {29'h0, sel}, 32'd0);
        check("arst_valid", {31'h0, sample_valid}, 32'd0);
        check("arst_bit", {31'h0, sample_bit}, 32'd0);
        check("arst_ch", {29'h0, sample_ch}, 32'd0);
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_fd", {31'h0, frame_done}, 32'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        sample_ready = 1'b1;
        step();
        check("arst_idle_valid", {31'h0, sample_valid}, 32'd0);
        push_frame(8'h0C, 8'hFF);
        do_start(8'h0C, 8'd0, 1'b0);
        check("arst_restart_sel", {29'h0, sel}, 32'd2);
        wait_idle("arst_restart", 100);
        check("arst_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
